// File: rtl/debounce_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debounce_event_ctrl
// Description : Multi-channel input synchronizer and debouncer sharing one
//               tick prescaler. Accepted level changes are arbitrated
//               round-robin into a first-word-fall-through event FIFO that
//               is drained over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_event_ctrl #(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 1000,
  parameter int DEB_TICKS  = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         p_sigIn,
  output logic [N_CH-1:0]         p_Debounced,
  output logic                    evt_valid,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_level,
  input  logic                    evt_ready,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int         C_CH_W   = $clog2(N_CH);
  localparam int         C_PC_W   = $clog2(TICK_DIV);
  localparam int         C_AW     = $clog2(FIFO_DEPTH);
  localparam int         C_CNT_W  = C_AW + 1;
  localparam int         C_ENT_W  = C_CH_W + 1;
  localparam logic [7:0] C_DEB_LAST = 8'(DEB_TICKS - 1);

  logic [N_CH-1:0]    r_sync1;
  logic [N_CH-1:0]    r_sync2;
  logic [C_PC_W-1:0]  r_pcnt;
  logic               w_tick;
  logic [7:0]         r_cnt [N_CH];
  logic [N_CH-1:0]    r_deb;
  logic [N_CH-1:0]    r_pend;
  logic [N_CH-1:0]    w_accept;
  logic [N_CH-1:0]    w_gnt_oh;
  logic               w_gnt_valid;
  logic [C_CH_W-1:0]  w_gnt_ch;
  logic [C_CH_W-1:0]  w_rr_idx;
  logic [C_CH_W-1:0]  r_last;
  logic [C_ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [C_AW-1:0]    r_wr_ptr;
  logic [C_AW-1:0]    r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               r_overflow;

  assign w_tick      = (r_pcnt == C_PC_W'(TICK_DIV - 1));
  assign w_full      = (r_count == C_CNT_W'(FIFO_DEPTH));
  assign w_push      = w_gnt_valid && !w_full;
  assign w_pop       = evt_valid && evt_ready;
  assign evt_valid   = (r_count != '0);
  assign evt_ch      = r_mem[r_rd_ptr][C_ENT_W-1:1];
  assign evt_level   = r_mem[r_rd_ptr][0];
  assign p_Debounced = r_deb;
  assign overflow    = r_overflow;

  // Two-flop synchronizer per channel; idle level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= p_sigIn;
      r_sync2 <= r_sync1;
    end
  end

  // Shared prescaler producing one tick every TICK_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + C_PC_W'(1);
    end
  end

  // A channel accepts its new level on the tick that completes DEB_TICKS of disagreement.
  for (genvar g = 0; g < N_CH; g++) begin : g_accept
    assign w_accept[g] = (r_sync2[g] != r_deb[g]) && w_tick && (r_cnt[g] == C_DEB_LAST);
  end

  // Per-channel disagreement counters and debounced levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb <= '1;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_cnt[i] <= '0;
          r_deb[i] <= r_sync2[i];
        end else if (w_tick) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Round-robin search for the first pending channel after the last grant.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_ch    = '0;
    w_rr_idx    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_rr_idx = C_CH_W'((int'(r_last) + i) % N_CH);
      if (!w_gnt_valid && r_pend[w_rr_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_ch    = w_rr_idx;
      end
    end
  end

  // One-hot mask of the channel whose pending event is pushed this cycle.
  always_comb begin
    w_gnt_oh = '0;
    if (w_push) w_gnt_oh[w_gnt_ch] = 1'b1;
  end

  // Pending bits and arbiter pointer; a fresh acceptance overrides a same-cycle grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_last <= C_CH_W'(N_CH - 1);
    end else begin
      r_pend <= (r_pend & ~w_gnt_oh) | w_accept;
      if (w_push) r_last <= w_gnt_ch;
    end
  end

  // Sticky overflow: an acceptance on a channel whose earlier event is still unqueued.
  // A grant in the same cycle queues the older level, so nothing is lost there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (|(w_accept & r_pend & ~w_gnt_oh)) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Event FIFO storage and pointers; the head is presented combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_gnt_ch, r_deb[w_gnt_ch]};
        r_wr_ptr        <= r_wr_ptr + C_AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_event_ctrl
// Description : Scoreboard bench for debounce_event_ctrl. Stimulus pushes the
//               expected {channel, level} events; a monitor pops and compares
//               each event the DUT hands over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_event_ctrl;

  localparam int N_CH       = 4;
  localparam int TICK_DIV   = 4;
  localparam int DEB_TICKS  = 3;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] p_sigIn;
  logic [3:0] p_Debounced;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_level;
  logic       evt_ready;
  logic       overflow;
  logic       clr_overflow;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [2:0] exp_q [$];
  logic [2:0] mon_exp;

  debounce_event_ctrl #(
    .N_CH       (N_CH),
    .TICK_DIV   (TICK_DIV),
    .DEB_TICKS  (DEB_TICKS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .p_sigIn      (p_sigIn),
    .p_Debounced  (p_Debounced),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_level    (evt_level),
    .evt_ready    (evt_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted event is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_event: got ch=%0d level=%0d, expected no event", evt_ch, evt_level);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event_ch_level", {29'd0, evt_ch, evt_level}, {29'd0, mon_exp});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    p_sigIn      = 4'hF;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    exp_q.delete();
    step(2);
    reset_n = 1'b1;
    step(2);
  endtask

  // Bounded wait for a channel's debounced level; returns edges elapsed.
  task automatic wait_deb(input int ch, input logic lvl, input int budget, output int cycles);
    cycles = 0;
    while (p_Debounced[ch] !== lvl && cycles < budget) begin
      step(1);
      cycles++;
    end
  endtask

  // Idle window: reports whether any event showed up or the debounced levels moved.
  task automatic watch(input int n, input logic [3:0] deb_exp, output bit saw_valid, output bit deb_moved);
    saw_valid = 1'b0;
    deb_moved = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (evt_valid !== 1'b0) saw_valid = 1'b1;
      if (p_Debounced !== deb_exp) deb_moved = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit saw_valid;
    bit deb_moved;

    // ---------------- Reset with random inputs ----------------
    reset_n      = 1'b0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    p_sigIn      = 4'($urandom);
    step(3);
    check("reset_debounced", {28'd0, p_Debounced}, 32'hF);
    check("reset_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("reset_overflow",  {31'd0, overflow},  32'd0);
    check("reset_evt_ch",    {30'd0, evt_ch},    32'd0);
    check("reset_evt_level", {31'd0, evt_level}, 32'd0);
    p_sigIn   = 4'hF;
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    watch(100, 4'hF, saw_valid, deb_moved);
    check("idle_no_event",   {31'd0, saw_valid}, 32'd0);
    check("idle_debounced",  {31'd0, deb_moved}, 32'd0);

    // ---------------- Clean press on ch2 ----------------
    do_reset();
    p_sigIn[2] = 1'b0;
    exp_q.push_back({2'd2, 1'b0});
    wait_deb(2, 1'b0, 40, cyc);
    check("press_latency_in_11_to_14", {31'd0, (cyc >= 11 && cyc <= 14)}, 32'd1);
    check("press_debounced", {28'd0, p_Debounced}, 32'hB);
    check("press_valid_not_yet", {31'd0, evt_valid}, 32'd0);
    step(1);
    check("press_valid_rise", {31'd0, evt_valid}, 32'd1);
    check("press_head", {29'd0, evt_ch, evt_level}, {29'd0, 2'd2, 1'b0});
    evt_ready = 1'b1;
    step(1);
    check("press_popped_empty", {31'd0, evt_valid}, 32'd0);
    check("press_queue_drained", exp_q.size(), 32'd0);

    // ---------------- Glitch rejection on ch1 ----------------
    do_reset();
    evt_ready  = 1'b1;
    p_sigIn[1] = 1'b0;
    step(7);
    p_sigIn[1] = 1'b1;
    step(1);
    p_sigIn[1] = 1'b0;
    step(7);
    p_sigIn[1] = 1'b1;
    watch(25, 4'hF, saw_valid, deb_moved);
    check("glitch_no_event",  {31'd0, saw_valid}, 32'd0);
    check("glitch_debounced", {31'd0, deb_moved}, 32'd0);

    // ---------------- Simultaneous changes, held head ----------------
    do_reset();
    p_sigIn = 4'h0;
    for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 1'b0});
    wait_deb(0, 1'b0, 40, cyc);
    check("simul_debounced", {28'd0, p_Debounced}, 32'h0);
    step(4);
    check("simul_head", {29'd0, evt_ch, evt_level}, {29'd0, 2'd0, 1'b0});
    p_sigIn[0] = 1'b1;
    exp_q.push_back({2'd0, 1'b1});
    step(20);
    check("simul_ch0_released", {28'd0, p_Debounced}, 32'h1);
    check("simul_head_held",   {29'd0, evt_valid, evt_ch}, {29'd0, 1'b1, 2'd0});
    check("simul_no_overflow", {31'd0, overflow}, 32'd0);
    evt_ready = 1'b1;
    step(10);
    check("simul_queue_drained", exp_q.size(), 32'd0);
    check("simul_empty", {31'd0, evt_valid}, 32'd0);

    // ---------------- Overflow on ch3 ----------------
    do_reset();
    p_sigIn = 4'h0;
    for (int c = 0; c < 4; c++) exp_q.push_back({2'(c), 1'b0});
    step(25);
    check("ovf_full_no_overflow", {31'd0, overflow}, 32'd0);
    p_sigIn[3] = 1'b1;
    step(20);
    check("ovf_first_toggle_level", {28'd0, p_Debounced}, 32'h8);
    check("ovf_pending_only", {31'd0, overflow}, 32'd0);
    p_sigIn[3] = 1'b0;
    exp_q.push_back({2'd3, 1'b0});
    step(20);
    check("ovf_second_toggle_level", {28'd0, p_Debounced}, 32'h0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    step(3);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    evt_ready = 1'b1;
    step(12);
    check("ovf_queue_drained", exp_q.size(), 32'd0);
    check("ovf_empty", {31'd0, evt_valid}, 32'd0);

    // ---------------- Reset mid-operation ----------------
    do_reset();
    p_sigIn = 4'h8;
    step(25);
    check("midrst_events_queued", {31'd0, evt_valid}, 32'd1);
    p_sigIn[3] = 1'b0;
    step(5);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("midrst_debounced", {28'd0, p_Debounced}, 32'hF);
    check("midrst_overflow",  {31'd0, overflow},  32'd0);
    p_sigIn = 4'hF;
    step(2);
    reset_n   = 1'b1;
    evt_ready = 1'b1;
    watch(40, 4'hF, saw_valid, deb_moved);
    check("midrst_no_stale_event", {31'd0, saw_valid}, 32'd0);
    check("midrst_debounced_idle", {31'd0, deb_moved}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
